// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: state encoding, arena geometry,
// game-rule constants and the movement-delta sign extension helper.
package maze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_HIT  = 3'd3,
        ST_WIN  = 3'd4,
        ST_OVER = 3'd5
    } game_state_e;

    localparam int POS_W  = 11;
    localparam int NWALL  = 25;
    localparam int FCNT_W = 8;

    localparam int H_START_DEF    = 130;
    localparam int V_START_DEF    = 332;
    localparam int PWIDTH_DEF     = 20;
    localparam int LEFT_BAR_DEF   = 121;
    localparam int RIGHT_BAR_DEF  = 520;
    localparam int TOP_BAR_DEF    = 2;
    localparam int BOTTOM_BAR_DEF = 400;
    localparam int GOAL_H_DEF     = 442;
    localparam int GOAL_V_DEF     = 58;
    localparam int LIVES_DEF      = 3;
    localparam int HIT_FRAMES_DEF = 30;
    localparam int WIN_FRAMES_DEF = 60;

    function automatic logic [POS_W-1:0] sext_delta(input logic [4:0] d);
        return {{(POS_W-5){d[4]}}, d};
    endfunction

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Maze-pattern handshake between the game controller and the LFSR wall source.
interface maze_game_ctrl_if #(
    parameter int NWALL = maze_pkg::NWALL
) ();
    logic             maze_req;
    logic             maze_ack;
    logic [NWALL-1:0] rand_h;
    logic [NWALL-1:0] rand_v;

    modport master (output maze_req, input maze_ack, input rand_h, input rand_v);
    modport slave  (input maze_req, output maze_ack, output rand_h, output rand_v);
endinterface

// File: rtl/maze_game_ctrl_move_decode.sv
// Splits the packed movement word into two sign-extended position deltas.
module move_decode
    import maze_pkg::*;
(
    input  logic [9:0]       move_data,
    output logic [POS_W-1:0] dx,
    output logic [POS_W-1:0] dy
);
    assign dx = sext_delta(move_data[9:5]);
    assign dy = sext_delta(move_data[4:0]);
endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: game FSM, player position/lives/level bookkeeping
// and the maze-pattern request to the LFSR source.
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int H_START    = H_START_DEF,
    parameter int V_START    = V_START_DEF,
    parameter int PWIDTH     = PWIDTH_DEF,
    parameter int LEFT_BAR   = LEFT_BAR_DEF,
    parameter int RIGHT_BAR  = RIGHT_BAR_DEF,
    parameter int TOP_BAR    = TOP_BAR_DEF,
    parameter int BOTTOM_BAR = BOTTOM_BAR_DEF,
    parameter int GOAL_H     = GOAL_H_DEF,
    parameter int GOAL_V     = GOAL_V_DEF,
    parameter int LIVES      = LIVES_DEF,
    parameter int HIT_FRAMES = HIT_FRAMES_DEF,
    parameter int WIN_FRAMES = WIN_FRAMES_DEF
) (
    input  logic             in_clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic [9:0]       movementData,
    input  logic             posr,
    input  logic             wall_hit,
    maze_game_ctrl_if.master maze_bus,
    output logic [NWALL-1:0] wall_h,
    output logic [NWALL-1:0] wall_v,
    output logic [POS_W-1:0] h_min,
    output logic [POS_W-1:0] v_min,
    output logic [1:0]       lives,
    output logic [3:0]       level,
    output logic [2:0]       state
);
    localparam int EXT_W = POS_W + 1;
    localparam logic [POS_W-1:0]  H_START_P = POS_W'(H_START);
    localparam logic [POS_W-1:0]  V_START_P = POS_W'(V_START);
    localparam logic [POS_W-1:0]  RIGHT_P   = POS_W'(RIGHT_BAR);
    localparam logic [POS_W-1:0]  BOTTOM_P  = POS_W'(BOTTOM_BAR);
    localparam logic [POS_W-1:0]  GOAL_H_P  = POS_W'(GOAL_H);
    localparam logic [POS_W-1:0]  GOAL_V_P  = POS_W'(GOAL_V);
    localparam logic [EXT_W-1:0]  PWIDTH_X  = EXT_W'(PWIDTH);
    localparam logic [EXT_W-1:0]  LEFT_X    = EXT_W'(LEFT_BAR);
    localparam logic [EXT_W-1:0]  TOP_X     = EXT_W'(TOP_BAR);
    localparam logic [1:0]        LIVES_P   = 2'(LIVES);
    localparam logic [FCNT_W-1:0] HIT_LAST  = FCNT_W'(HIT_FRAMES - 1);
    localparam logic [FCNT_W-1:0] WIN_LAST  = FCNT_W'(WIN_FRAMES - 1);

    // Reset asserts asynchronously but is released only on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end
    assign rst_n = rst_sync_q[1];

    game_state_e       state_q, state_d;
    logic [POS_W-1:0]  h_min_q, h_min_d, v_min_q, v_min_d;
    logic [1:0]        lives_q, lives_d;
    logic [3:0]        level_q, level_d;
    logic [NWALL-1:0]  wall_h_q, wall_h_d, wall_v_q, wall_v_d;
    logic              maze_req_q, maze_req_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic [POS_W-1:0] dx, dy, next_h, next_v;
    logic             blocked, at_goal;

    move_decode u_move_decode (
        .move_data (movementData),
        .dx        (dx),
        .dy        (dy)
    );

    // X input steers the vertical axis and Y the horizontal one.
    assign next_v  = v_min_q - dx;
    assign next_h  = h_min_q - dy;
    assign blocked = wall_hit
                  || (({1'b0, next_h} + PWIDTH_X) <= LEFT_X)
                  || (next_h >= RIGHT_P)
                  || (next_v >= BOTTOM_P)
                  || (({1'b0, next_v} + PWIDTH_X) <= TOP_X);
    assign at_goal = (h_min_q >= GOAL_H_P) && (v_min_q <= GOAL_V_P);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        h_min_d    = h_min_q;
        v_min_d    = v_min_q;
        lives_d    = lives_q;
        level_d    = level_q;
        wall_h_d   = wall_h_q;
        wall_v_d   = wall_v_q;
        maze_req_d = maze_req_q;
        fcnt_d     = fcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick && posr) begin
                    state_d    = ST_LOAD;
                    maze_req_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (maze_bus.maze_ack) begin
                    wall_h_d   = maze_bus.rand_h;
                    wall_v_d   = maze_bus.rand_v;
                    maze_req_d = 1'b0;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (posr) begin
                        h_min_d = H_START_P;
                        v_min_d = V_START_P;
                    end else if (blocked) begin
                        lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                        h_min_d = H_START_P;
                        v_min_d = V_START_P;
                        fcnt_d  = '0;
                        state_d = ST_HIT;
                    end else if (at_goal) begin
                        level_d = (level_q == 4'hF) ? level_q : level_q + 4'd1;
                        fcnt_d  = '0;
                        state_d = ST_WIN;
                    end else begin
                        h_min_d = next_h;
                        v_min_d = next_v;
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (fcnt_q == HIT_LAST) begin
                        fcnt_d  = '0;
                        state_d = (lives_q == 2'd0) ? ST_OVER : ST_PLAY;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            ST_WIN: begin
                if (frame_tick) begin
                    if (fcnt_q == WIN_LAST) begin
                        fcnt_d     = '0;
                        h_min_d    = H_START_P;
                        v_min_d    = V_START_P;
                        maze_req_d = 1'b1;
                        state_d    = ST_LOAD;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (frame_tick && posr) begin
                    lives_d    = LIVES_P;
                    level_d    = 4'd0;
                    h_min_d    = H_START_P;
                    v_min_d    = V_START_P;
                    maze_req_d = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            h_min_q    <= H_START_P;
            v_min_q    <= V_START_P;
            lives_q    <= LIVES_P;
            level_q    <= 4'd0;
            wall_h_q   <= '0;
            wall_v_q   <= '0;
            maze_req_q <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            h_min_q    <= h_min_d;
            v_min_q    <= v_min_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            wall_h_q   <= wall_h_d;
            wall_v_q   <= wall_v_d;
            maze_req_q <= maze_req_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign maze_bus.maze_req = maze_req_q;
    assign wall_h = wall_h_q;
    assign wall_v = wall_v_q;
    assign h_min  = h_min_q;
    assign v_min  = v_min_q;
    assign lives  = lives_q;
    assign level  = level_q;
    assign state  = state_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Scoreboard bench for maze_game_ctrl: the driver queues the hand-computed
// outcome of every frame_tick / maze_ack strobe, the monitor checks it.
module tb_maze_game_ctrl;
    import maze_pkg::*;

    typedef struct {
        string            tag;
        logic [2:0]       st;
        logic [10:0]      h;
        logic [10:0]      v;
        logic [1:0]       lives;
        logic [3:0]       level;
        logic             req;
        logic [NWALL-1:0] wh;
        logic [NWALL-1:0] wv;
    } exp_t;

    logic             in_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             frame_tick = 1'b0;
    logic             posr = 1'b0;
    logic             wall_hit = 1'b0;
    logic [9:0]       movementData = '0;
    logic [NWALL-1:0] wall_h, wall_v;
    logic [10:0]      h_min, v_min;
    logic [1:0]       lives;
    logic [3:0]       level;
    logic [2:0]       state;

    maze_game_ctrl_if bus ();

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [NWALL-1:0] exp_wh = '0;
    logic [NWALL-1:0] exp_wv = '0;

    always #5 in_clk = ~in_clk;

    maze_game_ctrl dut (
        .in_clk       (in_clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .movementData (movementData),
        .posr         (posr),
        .wall_hit     (wall_hit),
        .maze_bus     (bus),
        .wall_h       (wall_h),
        .wall_v       (wall_v),
        .h_min        (h_min),
        .v_min        (v_min),
        .lives        (lives),
        .level        (level),
        .state        (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void expect_out(input string tag, input logic [2:0] st, input int h, input int v,
                                       input int lv, input int lvl, input logic req);
        exp_t e;
        e.tag   = tag;
        e.st    = st;
        e.h     = 11'(h);
        e.v     = 11'(v);
        e.lives = 2'(lv);
        e.level = 4'(lvl);
        e.req   = req;
        e.wh    = exp_wh;
        e.wv    = exp_wv;
        exp_q.push_back(e);
    endfunction

    // Monitor: any strobe sampled on a rising edge has its outcome checked half a cycle later.
    initial begin
        logic ev;
        exp_t e;
        forever begin
            @(posedge in_clk);
            ev = frame_tick || bus.maze_ack;
            @(negedge in_clk);
            if (ev) begin
                check("scoreboard_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({e.tag, ".state"}, 32'(state), 32'(e.st));
                    check({e.tag, ".h_min"}, 32'(h_min), 32'(e.h));
                    check({e.tag, ".v_min"}, 32'(v_min), 32'(e.v));
                    check({e.tag, ".lives"}, 32'(lives), 32'(e.lives));
                    check({e.tag, ".level"}, 32'(level), 32'(e.level));
                    check({e.tag, ".maze_req"}, 32'(bus.maze_req), 32'(e.req));
                    check({e.tag, ".wall_h"}, 32'(wall_h), 32'(e.wh));
                    check({e.tag, ".wall_v"}, 32'(wall_v), 32'(e.wv));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic frame(input string tag, input logic [9:0] mv, input logic p, input logic hit,
                         input logic [2:0] st, input int h, input int v, input int lv, input int lvl,
                         input logic req, input int gap = 1);
        movementData = mv;
        posr         = p;
        wall_hit     = hit;
        frame_tick   = 1'b1;
        expect_out(tag, st, h, v, lv, lvl, req);
        @(negedge in_clk);
        frame_tick   = 1'b0;
        posr         = 1'b0;
        wall_hit     = 1'b0;
        movementData = '0;
        repeat (gap) @(negedge in_clk);
    endtask

    // Entered on the first negedge in LOAD; maze_ack is sampled on the delay-th edge after entry.
    task automatic load_maze(input string tag, input logic [NWALL-1:0] rh, input logic [NWALL-1:0] rv,
                             input int delay, input bit poke, input int lv, input int lvl);
        int req_cycles = 0;
        bus.rand_h = rh;
        bus.rand_v = rv;
        for (int i = 0; i < delay; i++) begin
            frame_tick = 1'b0;
            posr       = 1'b0;
            if (bus.maze_req) req_cycles++;
            if (poke && i == 1) begin
                frame_tick = 1'b1;
                posr       = 1'b1;
                expect_out({tag, "_tick_ignored"}, ST_LOAD, 130, 332, lv, lvl, 1'b1);
            end
            if (i == delay - 1) begin
                exp_wh       = rh;
                exp_wv       = rv;
                bus.maze_ack = 1'b1;
                expect_out({tag, "_ack"}, ST_PLAY, 130, 332, lv, lvl, 1'b0);
            end
            @(negedge in_clk);
        end
        bus.maze_ack = 1'b0;
        frame_tick   = 1'b0;
        posr         = 1'b0;
        check({tag, "_req_cycles"}, 32'(req_cycles), 32'(delay));
        @(negedge in_clk);
    endtask

    task automatic hold_frames(input string tag, input int n, input logic [2:0] st_wait,
                               input logic [2:0] st_exit, input int lv, input int lvl);
        for (int i = 0; i < n; i++)
            frame(tag, 10'h00F, 1'b0, 1'b0, (i < n - 1) ? st_wait : st_exit, 130, 332, lv, lvl, 1'b0);
    endtask

    // 20 steps from the start box to (450,50), one idle frame to register the goal, then the win wait.
    task automatic run_to_goal(input string tag, input int lv, input int lvl_in, output int lvl_out);
        int h = 130;
        int v = 332;
        logic [4:0] dx;
        for (int i = 0; i < 20; i++) begin
            dx = (i < 18) ? 5'd15 : (i == 18) ? 5'd12 : 5'd0;
            h += 16;
            v -= int'(dx);
            frame({tag, "_step"}, {dx, 5'b10000}, 1'b0, 1'b0, ST_PLAY, h, v, lv, lvl_in, 1'b0);
        end
        lvl_out = (lvl_in == 15) ? 15 : lvl_in + 1;
        frame({tag, "_goal"}, '0, 1'b0, 1'b0, ST_WIN, 450, 50, lv, lvl_out, 1'b0);
        for (int i = 0; i < 59; i++)
            frame({tag, "_win_wait"}, 10'h00F, 1'b0, 1'b0, ST_WIN, 450, 50, lv, lvl_out, 1'b0);
        frame({tag, "_win_done"}, '0, 1'b0, 1'b0, ST_LOAD, 130, 332, lv, lvl_out, 1'b1, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".state"}, 32'(state), 32'(ST_IDLE));
        check({tag, ".h_min"}, 32'(h_min), 32'd130);
        check({tag, ".v_min"}, 32'(v_min), 32'd332);
        check({tag, ".lives"}, 32'(lives), 32'd3);
        check({tag, ".level"}, 32'(level), 32'd0);
        check({tag, ".wall_h"}, 32'(wall_h), 32'd0);
        check({tag, ".wall_v"}, 32'(wall_v), 32'd0);
        check({tag, ".maze_req"}, 32'(bus.maze_req), 32'd0);
    endtask

    initial begin
        int lvl;
        bus.maze_ack = 1'b0;
        bus.rand_h   = '0;
        bus.rand_v   = '0;

        #12 check_reset("reset");
        @(negedge in_clk);
        reset_n = 1'b1;
        repeat (4) @(negedge in_clk);

        frame("idle_no_posr", '0, 1'b0, 1'b0, ST_IDLE, 130, 332, 3, 0, 1'b0);
        frame("start", '0, 1'b1, 1'b0, ST_LOAD, 130, 332, 3, 0, 1'b1, 0);
        load_maze("load1", 25'h1555555, 25'h0AAAAAA, 5, 1'b1, 3, 0);

        frame("move_dxm2_dyp1", {5'b11110, 5'b00001}, 1'b0, 1'b0, ST_PLAY, 129, 334, 3, 0, 1'b0);
        frame("posr_beats_hit", 10'h2A5, 1'b1, 1'b1, ST_PLAY, 130, 332, 3, 0, 1'b0);
        frame("zero_delta_holds", '0, 1'b0, 1'b0, ST_PLAY, 130, 332, 3, 0, 1'b0);

        frame("left_step", 10'h00F, 1'b0, 1'b0, ST_PLAY, 115, 332, 3, 0, 1'b0);
        frame("left_edge_clear", 10'h00D, 1'b0, 1'b0, ST_PLAY, 102, 332, 3, 0, 1'b0);
        frame("left_edge_touch", 10'h001, 1'b0, 1'b0, ST_HIT, 130, 332, 2, 0, 1'b0);
        hold_frames("hit1_wait", 30, ST_HIT, ST_PLAY, 2, 0);

        frame("wall_hit2", 10'h001, 1'b0, 1'b1, ST_HIT, 130, 332, 1, 0, 1'b0);
        hold_frames("hit2_wait", 30, ST_HIT, ST_PLAY, 1, 0);

        frame("down1", 10'h200, 1'b0, 1'b0, ST_PLAY, 130, 348, 1, 0, 1'b0);
        frame("down2", 10'h200, 1'b0, 1'b0, ST_PLAY, 130, 364, 1, 0, 1'b0);
        frame("down3", 10'h200, 1'b0, 1'b0, ST_PLAY, 130, 380, 1, 0, 1'b0);
        frame("down4", 10'h200, 1'b0, 1'b0, ST_PLAY, 130, 396, 1, 0, 1'b0);
        frame("bottom_edge_clear", 10'h3A0, 1'b0, 1'b0, ST_PLAY, 130, 399, 1, 0, 1'b0);
        frame("bottom_edge_touch", 10'h3E0, 1'b0, 1'b0, ST_HIT, 130, 332, 0, 0, 1'b0);
        hold_frames("hit3_wait", 30, ST_HIT, ST_OVER, 0, 0);

        frame("over_holds", 10'h001, 1'b0, 1'b1, ST_OVER, 130, 332, 0, 0, 1'b0);
        frame("over_restart", '0, 1'b1, 1'b0, ST_LOAD, 130, 332, 3, 0, 1'b1, 0);
        load_maze("load2", 25'h0F0F0F0, 25'h1234567, 3, 1'b0, 3, 0);

        lvl = 0;
        for (int r = 0; r < 16; r++) begin
            run_to_goal($sformatf("win%0d", r), 3, lvl, lvl);
            if (r < 15)
                load_maze($sformatf("reload%0d", r), 25'h1FFFFFF ^ 25'(r), 25'(r * 3), 2, 1'b0, 3, lvl);
        end

        repeat (2) @(negedge in_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("req_before_reset", 32'(bus.maze_req), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset("mid_load_reset");
        @(negedge in_clk);
        reset_n = 1'b1;
        repeat (3) @(negedge in_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_game_ctrl.md
MAZE_GAME_CTRL -- requirements
Module: maze_game_ctrl

Interface
REQ-001 Parameter H_START, 130: player h_min after reset, restart or hit.
REQ-002 Parameter V_START, 332: player v_min after reset, restart or hit.
REQ-003 Parameter PWIDTH, 20: player box size; h_max = h_min+PWIDTH, v_max = v_min+PWIDTH.
REQ-004 Parameters LEFT_BAR 121, RIGHT_BAR 520, TOP_BAR 2, BOTTOM_BAR 400: arena limits.
REQ-005 Parameters GOAL_H 442, GOAL_V 58: goal when h_min>=GOAL_H and v_min<=GOAL_V.
REQ-006 Parameters LIVES 3, HIT_FRAMES 30, WIN_FRAMES 60, NWALL 25.
REQ-007 in_clk  input  1  sole clock, all logic posedge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 frame_tick  input  1  one-cycle strobe per frame (vcnt==481, hcnt==0), in_clk domain.
REQ-010 movementData  input  10  [9:5] X delta, [4:0] Y delta, 5-bit two's complement each.
REQ-011 posr  input  1  restart/start request, level-sampled on frame_tick.
REQ-012 wall_hit  input  1  pixel-overlap flag from the renderer for the current position, sampled on frame_tick.
REQ-013 rand_h, rand_v  input  NWALL each  LFSR wall patterns.
REQ-014 maze_ack  input  1  LFSR source confirms rand_h/rand_v stable.
REQ-015 maze_req  output  1  request for a new maze pattern.
REQ-016 wall_h, wall_v  output  NWALL each  latched wall masks; 1 = wall drawn.
REQ-017 h_min, v_min  output  11 each  player top-left position.
REQ-018 lives  output  2; level  output  4; state  output  3 (encoded game state).

Function
REQ-019 States: IDLE, LOAD, PLAY, HIT, WIN, OVER. Transitions are registered, one per cycle at most.
REQ-020 IDLE->LOAD on frame_tick with posr=1.
REQ-021 LOAD: maze_req=1 from LOAD entry. In the first cycle with maze_ack=1: latch rand_h->wall_h and rand_v->wall_v, drop maze_req next cycle, go to PLAY. The block waits indefinitely for maze_ack.
REQ-022 PLAY, per frame_tick:
  - next_v = v_min - sext(dx); next_h = h_min - sext(dy); mod 2^11.
  - Priority: posr > wall_hit > boundary > goal > move.
REQ-023 PLAY posr=1: h_min/v_min <- start values; stay in PLAY; lives unchanged.
REQ-024 PLAY wall_hit=1, or next box touches a limit (LEFT_BAR>=next_h+PWIDTH, RIGHT_BAR<=next_h, BOTTOM_BAR<=next_v, TOP_BAR>=next_v+PWIDTH): position not committed; lives decremented; go to HIT.
REQ-025 PLAY goal met at the current position: go to WIN; position not updated.
REQ-026 Otherwise commit next_h/next_v. Zero delta holds the position.
REQ-027 HIT: position <- start on entry; frame counter counts HIT_FRAMES frame_ticks.
  - If lives==0 then go to OVER, else go to PLAY.
  - Walls unchanged.
REQ-028 WIN: level saturating increment (15 holds) on entry; after WIN_FRAMES frame_ticks, position <- start, go to LOAD.
REQ-029 OVER: holds all outputs. frame_tick with posr=1 sets lives<-LIVES, level<-0, position<-start, goes to LOAD.
REQ-030 lives never wraps below 0. frame_tick outside PLAY/HIT/WIN/OVER/IDLE is ignored. frame_tick during LOAD is ignored.
REQ-031 Output latency: all outputs are registered and update the cycle after the deciding frame_tick or maze_ack edge.

Reset
REQ-032 reset_n low, asynchronously:
  - state=IDLE, h_min=H_START, v_min=V_START.
  - lives=LIVES, level=0, wall_h=wall_v=0, maze_req=0, frame counter=0.
REQ-033 Reset mid-LOAD drops maze_req immediately. Release is synchronised so that the first post-reset edge sees reset deasserted.

Structure
REQ-034 Package maze_pkg holds the state encoding, arena/goal geometry constants, LIVES, NWALL and frame counts, shared with the renderer.
REQ-035 Sub-module move_decode: 10-bit movementData -> two sign-extended 11-bit deltas, purely combinational.

Verification
REQ-036 Reset, then posr+frame_tick, then maze_ack after 5 cycles with rand_h=0x1555555: maze_req high 5 cycles; wall_h=0x1555555; state=PLAY.
REQ-037 PLAY at (130,332), movementData={5'b11110,5'b00001} (dx=-2, dy=+1), frame_tick: h_min=129, v_min=334.
REQ-038 PLAY, wall_hit=1 and posr=1 on the same frame_tick: position=(130,332), lives unchanged, state=PLAY.
REQ-039 Three wall_hits each followed by 30 frames: lives 3->2->1->0; after the third hit plus 30 frames, state=OVER. posr+frame_tick then gives lives=3, level=0, state=LOAD.
REQ-040 Position (450,50), frame_tick: state=WIN, level+1. After 60 frames, maze_req=1 and position=(130,332). Level at 15 stays 15.
